// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared defaults and stability-counter sizing for the debounce block
package debounce_pkg;

    localparam int unsigned DEF_STABLE_CYCLES = 4;
    localparam int unsigned DEF_CNT_WIDTH     = 32;

    // ceil(log2(stable+1)), never less than one bit
    function automatic int unsigned sc_width(input int unsigned stable);
        int unsigned w;
        w = 1;
        while ((64'd1 << w) < (64'(stable) + 64'd1)) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/debounce_pulse_counter_if.sv
// rtl/debounce_pulse_counter_if.sv - button input, clear and debounced outputs of the press counter
interface debounce_pulse_counter_if
    import debounce_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = DEF_CNT_WIDTH
);
    logic                 i;
    logic                 zero;
    logic                 st_o;
    logic                 up_o;
    logic                 dn_o;
    logic [CNT_WIDTH-1:0] out;

    modport master (
        output i,
        output zero,
        input  st_o,
        input  up_o,
        input  dn_o,
        input  out
    );

    modport slave (
        input  i,
        input  zero,
        output st_o,
        output up_o,
        output dn_o,
        output out
    );
endinterface

// File: rtl/debounce_filter.sv
// rtl/debounce_filter.sv - two-flop synchronizer and stability filter with registered edge strobes
module debounce_filter
    import debounce_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i,
    output logic st_o,
    output logic up_o,
    output logic dn_o
);

    localparam int unsigned    SC_W    = sc_width(STABLE_CYCLES);
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(STABLE_CYCLES - 1);

    logic            s1_q, s1_d;
    logic            s_q, s_d;
    logic            st_q, st_d;
    logic            up_q, up_d;
    logic            dn_q, dn_d;
    logic [SC_W-1:0] sc_q, sc_d;

    // any cycle agreeing with the current level restarts qualification
    always_comb begin
        s1_d = i;
        s_d  = s1_q;
        sc_d = sc_q;
        st_d = st_q;
        up_d = 1'b0;
        dn_d = 1'b0;
        if (s_q == st_q) begin
            sc_d = '0;
        end else if (sc_q == SC_LAST) begin
            sc_d = '0;
            st_d = s_q;
            up_d = s_q;
            dn_d = ~s_q;
        end else begin
            sc_d = sc_q + SC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s_q  <= 1'b0;
            sc_q <= '0;
            st_q <= 1'b0;
            up_q <= 1'b0;
            dn_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s_q  <= s_d;
            sc_q <= sc_d;
            st_q <= st_d;
            up_q <= up_d;
            dn_q <= dn_d;
        end
    end

    assign st_o = st_q;
    assign up_o = up_q;
    assign dn_o = dn_q;

endmodule

// File: rtl/debounce_pulse_counter.sv
// rtl/debounce_pulse_counter.sv - debounced button with a wrapping press counter and synchronous clear
module debounce_pulse_counter
    import debounce_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int unsigned CNT_WIDTH     = DEF_CNT_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    debounce_pulse_counter_if.slave  bus
);

    logic [CNT_WIDTH-1:0] out_q, out_d;

    debounce_filter #(
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_filter (
        .clk   (clk),
        .rst_n (rst_n),
        .i     (bus.i),
        .st_o  (bus.st_o),
        .up_o  (bus.up_o),
        .dn_o  (bus.dn_o)
    );

    // clear wins over a coincident press, which is then dropped
    always_comb begin
        out_d = out_q;
        if (bus.zero) begin
            out_d = '0;
        end else if (bus.up_o) begin
            out_d = out_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign bus.out = out_q;

endmodule

// File: tb/tb_debounce_pulse_counter.sv
// tb/tb_debounce_pulse_counter.sv - directed bench with a windowed reference model for the debounce counter
module tb_debounce_pulse_counter;

    localparam int STABLE = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic i_r   = 1'b0;
    logic zero_r = 1'b0;

    always #10 clk = ~clk;

    debounce_pulse_counter_if #(.CNT_WIDTH(32)) bus32();
    debounce_pulse_counter_if #(.CNT_WIDTH(4))  bus4();

    assign bus32.i    = i_r;
    assign bus32.zero = zero_r;
    assign bus4.i     = i_r;
    assign bus4.zero  = zero_r;

    debounce_pulse_counter #(.STABLE_CYCLES(STABLE), .CNT_WIDTH(32)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus32)
    );

    debounce_pulse_counter #(.STABLE_CYCLES(STABLE), .CNT_WIDTH(4)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the level flips once the last STABLE synchronized samples all disagree with it.
    logic        m_p1, m_p2, m_st, m_up, m_dn;
    logic [31:0] m_cnt;
    logic [3:0]  m_cnt4;
    logic        s_used, flip, old_up;
    bit          hist[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_p1 = 0; m_p2 = 0; m_st = 0; m_up = 0; m_dn = 0;
            m_cnt = 0; m_cnt4 = 0;
            hist.delete();
            for (int k = 0; k < STABLE; k++) hist.push_back(1'b0);
        end else begin
            s_used = m_p2;
            m_p2   = m_p1;
            m_p1   = i_r;
            old_up = m_up;
            hist.push_back(s_used);
            void'(hist.pop_front());
            flip = 1'b1;
            foreach (hist[k]) if (hist[k] == m_st) flip = 1'b0;
            m_up = flip & ~m_st;
            m_dn = flip & m_st;
            if (flip) m_st = ~m_st;
            if (zero_r) begin
                m_cnt  = 0;
                m_cnt4 = 0;
            end else if (old_up) begin
                m_cnt  = m_cnt + 1;
                m_cnt4 = m_cnt4 + 1;
            end
        end
    end

    int ups = 0;
    int dns = 0;

    always @(negedge clk) begin
        check("cyc_st",   bus32.st_o, m_st);
        check("cyc_up",   bus32.up_o, m_up);
        check("cyc_dn",   bus32.dn_o, m_dn);
        check("cyc_out",  bus32.out,  m_cnt);
        check("cyc_out4", bus4.out,   m_cnt4);
        check("cyc_st4",  bus4.st_o,  m_st);
        if (bus32.up_o === 1'b1) ups++;
        if (bus32.dn_o === 1'b1) dns++;
    end

    int bw[22] = '{6, 12, 8, 30, 14, 36, 10, 20, 6, 24, 16, 34, 8, 28, 12, 22, 18, 36, 10, 30, 14, 26};

    task automatic press();
        i_r = 1'b1;
        repeat (10) @(negedge clk);
        #1 i_r = 1'b0;
        repeat (10) @(negedge clk);
        #1;
    endtask

    bit seen;

    initial begin
        // reset held while the input toggles
        repeat (6) begin
            @(negedge clk);
            #1 i_r = ~i_r;
        end
        check("rst_st",  bus32.st_o, 0);
        check("rst_up",  bus32.up_o, 0);
        check("rst_out", bus32.out,  0);
        i_r = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (10) @(negedge clk);
        #1;

        // bouncy press
        ups = 0; dns = 0;
        foreach (bw[k]) begin
            i_r = ~i_r;
            #(bw[k]);
        end
        i_r = 1'b1;
        #500;
        check("press_st",  bus32.st_o, 1);
        check("press_out", bus32.out,  1);
        check("press_ups", ups,        1);

        // bouncy release
        foreach (bw[k]) begin
            i_r = ~i_r;
            #(bw[k]);
        end
        i_r = 1'b0;
        #500;
        check("rel_st",  bus32.st_o, 0);
        check("rel_out", bus32.out,  1);
        check("rel_dns", dns,        1);

        i_r = 1'b1;
        #500;
        i_r = 1'b0;
        #500;
        check("clean_out", bus32.out, 2);

        // threshold: three synchronized samples are rejected, four are accepted
        @(negedge clk);
        #1 i_r = 1'b1;
        repeat (3) @(posedge clk);
        #1 i_r = 1'b0;
        repeat (10) @(negedge clk);
        check("thr3_out", bus32.out, 2);
        #1 i_r = 1'b1;
        repeat (4) @(posedge clk);
        #1 i_r = 1'b0;
        repeat (10) @(negedge clk);
        check("thr4_out", bus32.out, 3);

        // asynchronous reset during qualification, then button held through release
        #1 i_r = 1'b1;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #2;
        check("arst_out", bus32.out,  0);
        check("arst_st",  bus32.st_o, 0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1 check("hold_st5", bus32.st_o, 0);
        @(posedge clk);
        #1 check("hold_st6", bus32.st_o, 1);
        check("hold_up6", bus32.up_o, 1);
        repeat (10) @(negedge clk);
        #1 i_r = 1'b0;
        repeat (10) @(negedge clk);
        #1 check("hold_out", bus32.out, 1);

        // clear coinciding with a press strobe
        repeat (4) press();
        check("pre_clr_out", bus32.out, 5);
        i_r = 1'b1;
        seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (bus32.up_o === 1'b1) seen = 1;
        end
        check("clr_up_seen", seen, 1);
        #1 zero_r = 1'b1;
        @(negedge clk);
        #1 zero_r = 1'b0;
        check("clr_out", bus32.out, 0);
        repeat (10) @(negedge clk);
        #1 i_r = 1'b0;
        repeat (10) @(negedge clk);
        #1 press();
        check("after_clr_out", bus32.out, 1);

        // wrap on the 4-bit counter
        zero_r = 1'b1;
        @(negedge clk);
        #1 zero_r = 1'b0;
        check("wrap_clr", bus4.out, 0);
        repeat (15) press();
        check("wrap_15", bus4.out, 15);
        press();
        check("wrap_0",  bus4.out, 0);
        check("wrap_32", bus32.out, 16);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
